// File: rtl/mdr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdr_pkg
// Purpose  : Shared datapath constants used by the datapath registers.
// Revision : 1.0 - initial release
// ============================================================================
package mdr_pkg;

    // Width of every datapath word
    localparam int DATA_WIDTH = 32;

    // Reset contents: every bit cleared (fill bit lets other widths reuse it)
    localparam logic                  RESET_FILL  = 1'b0;
    localparam logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{RESET_FILL}};

endpackage : mdr_pkg
`default_nettype wire

// File: rtl/mdr_dp_register.sv
`default_nettype none
// ============================================================================
// Module   : dp_register
// Purpose  : Generic datapath register with asynchronous active-high clear
//            and a synchronous load enable.
// Revision : 1.0 - initial release
// ============================================================================
module dp_register
    import mdr_pkg::*;
#(
    parameter int WIDTH = mdr_pkg::DATA_WIDTH
) (
    input  logic             clock_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Clear is asynchronous and dominates; otherwise capture on enabled edges
    always_ff @(posedge clock_i or posedge clear_i) begin
        if (clear_i) begin
            data_q <= {WIDTH{RESET_FILL}};
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule : dp_register
`default_nettype wire

// File: rtl/mdr.sv
`default_nettype none
// ============================================================================
// Module   : mdr
// Purpose  : Memory Data Register. Holds one word that is loaded either from
//            memory read data or from the internal bus, and presents it to
//            both the bus mux and the memory write-data path.
// Revision : 1.0 - initial release
// ============================================================================
module mdr
    import mdr_pkg::*;
#(
    parameter int DATA_WIDTH = mdr_pkg::DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  read,
    input  logic                  MDRin,
    input  logic [DATA_WIDTH-1:0] Mdatain,
    input  logic [DATA_WIDTH-1:0] BusMuxOut,
    output logic [DATA_WIDTH-1:0] memOut
);

    logic [DATA_WIDTH-1:0] next_data_d;

    // Source select: memory read data when read=1, otherwise the bus value
    always_comb begin
        next_data_d = BusMuxOut;
        if (read) begin
            next_data_d = Mdatain;
        end
    end

    // Storage element; memOut comes straight from the flops, never from inputs
    dp_register #(
        .WIDTH (DATA_WIDTH)
    ) u_store (
        .clock_i (clock),
        .clear_i (clear),
        .load_i  (MDRin),
        .d_i     (next_data_d),
        .q_o     (memOut)
    );

endmodule : mdr
`default_nettype wire

// File: tb/tb_mdr.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdr
// Purpose  : Self-checking bench for mdr. A driver issues one stimulus set
//            per cycle and pushes the value memOut must show in that cycle;
//            a monitor pops and compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdr;

    localparam int W = 32;

    logic         clk;
    logic         clear;
    logic         read;
    logic         MDRin;
    logic [W-1:0] Mdatain;
    logic [W-1:0] BusMuxOut;
    logic [W-1:0] memOut;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    string        name_q[$];

    // Reference state: the word the register holds after the most recent edge
    logic [W-1:0] model;

    mdr #(.DATA_WIDTH(W)) dut (
        .clock     (clk),
        .clear     (clear),
        .read      (read),
        .MDRin     (MDRin),
        .Mdatain   (Mdatain),
        .BusMuxOut (BusMuxOut),
        .memOut    (memOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus 1 ns after the rising edge (well away from
    // either edge). What memOut must show this cycle: zero if clear is up now,
    // else whatever the last edge stored. Then advance the model to the
    // value the coming edge will store.
    task automatic cycle(input logic c, input logic m, input logic r,
                         input logic [W-1:0] md, input logic [W-1:0] bus,
                         input string name);
        @(posedge clk);
        #1;
        clear     = c;
        MDRin     = m;
        read      = r;
        Mdatain   = md;
        BusMuxOut = bus;
        exp_q.push_back(c ? '0 : model);
        name_q.push_back(name);
        if (c)      model = '0;
        else if (m) model = r ? md : bus;
    endtask

    // Monitor: compare on each falling edge for which an expectation exists
    initial begin
        logic [W-1:0] e;
        string        n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (memOut !== e) begin
                    errors++;
                    $display("FAIL %s: memOut=%h expected %h", n, memOut, e);
                end
            end
        end
    end

    // Driver
    initial begin
        logic         c, m, r;
        logic [W-1:0] md, bus;
        int           waited;

        clear     = 1'b1;
        MDRin     = 1'b0;
        read      = 1'b0;
        Mdatain   = 32'h1234_5678;
        BusMuxOut = '0;
        model     = '0;

        // Reset held for two clocks with a live memory word present
        cycle(1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h0, "reset0");
        cycle(1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h0, "reset1");
        cycle(1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h0, "release");

        // Memory load, then bus load, then load a known hold pattern
        cycle(1'b0, 1'b1, 1'b1, 32'h8765_4321, 32'h0000_0001, "memload_before_edge");
        cycle(1'b0, 1'b1, 1'b0, 32'h8765_4321, 32'h0000_0001, "memload");
        cycle(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000, "busload");

        // Hold for three clocks while every input is driven to all ones
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "hold0");
        cycle(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "hold1");
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "hold2");

        // Async clear mid-cycle with a load pending, clear priority, recovery
        cycle(1'b1, 1'b1, 1'b1, 32'hA5A5_A5A5, 32'h0, "async_clear");
        cycle(1'b1, 1'b1, 1'b1, 32'hA5A5_A5A5, 32'h0, "clear_priority");
        cycle(1'b0, 1'b1, 1'b1, 32'hA5A5_A5A5, 32'h0, "clear_release");
        cycle(1'b0, 1'b0, 1'b0, 32'h0,         32'h0, "recover");

        // Randomized traffic with occasional clears
        for (int i = 0; i < 200; i++) begin
            c   = ($urandom_range(0, 15) == 0);
            m   = $urandom_range(0, 1);
            r   = $urandom_range(0, 1);
            md  = $urandom;
            bus = $urandom;
            cycle(c, m, r, md, bus, "random");
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "final");

        // Let the monitor drain, with a bounded wait
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mdr
`default_nettype wire

// File: doc/mdr.md
Name: mdr

Overview:
- Memory Data Register for the datapath: a 32-bit holding register between system bus and memory interface.
- Loads either incoming memory data (Mdatain) or the internal bus value (BusMuxOut), chosen by `read`, when enabled by `MDRin`.
- Held value is presented continuously on `memOut`, which feeds both the bus mux and the memory write-data path.

Parameters:
- DATA_WIDTH, 32, width of data inputs, stored register and output.

Ports:
- clock  input  1  system clock; all loads on rising edge.
- clear  input  1  asynchronous, active-high reset; forces stored value to 0.
- read  input  1  source select: 1 = Mdatain (memory read), 0 = BusMuxOut (bus write).
- MDRin  input  1  load enable. Only bit 0 is significant; wider drivers are truncated to the LSB.
- Mdatain  input  DATA_WIDTH  data returned from memory.
- BusMuxOut  input  DATA_WIDTH  value on the internal datapath bus.
- memOut  output  DATA_WIDTH  current register contents.

Behaviour:
- Reset:
  - `clear`=1 forces the register, and therefore `memOut`, to 0 immediately, independent of `clock`.
  - Reset holds for as long as `clear` stays high; `MDRin` and `read` are ignored while `clear`=1.
  - Deassertion of `clear` takes effect at the next rising edge; no synchronizer is inside this block.
- Input mux (combinational): next_data = read ? Mdatain : BusMuxOut.
- Load: at a rising edge of `clock` with `clear`=0 and `MDRin`=1, the register captures next_data.
- Hold: with `MDRin`=0 the register keeps its value regardless of `read`, Mdatain or BusMuxOut changes.
- Latency:
  - `memOut` reflects the loaded value one clock edge after the load is sampled.
  - There is no combinational path from any data input to `memOut`.
- Sampling: `read`, `MDRin` and the data inputs are sampled only at the rising edge. Glitches between edges have no effect.
- Simultaneous events:
  - `clear` high at a rising edge with `MDRin`=1: clear wins, result is 0.
  - `read` toggling in the same cycle as `MDRin`: the value sampled at the edge selects the source.
- Reset mid-operation: asserting `clear` between edges zeroes `memOut` at once. No pending load survives.
- No handshake and no busy state; a load completes every enabled cycle. Back-to-back loads are allowed every cycle.
- Width: all data paths are exactly DATA_WIDTH; no sign extension, truncation or arithmetic.

Decomposition:
- Shared datapath package holds DATA_WIDTH (32) and the reset value constant (all zeros). The other datapath registers use the same package.
- One natural sub-module: `dp_register`, a generic DATA_WIDTH register with async active-high clear and load enable, reused by other datapath registers.
- mdr = 2:1 input mux + one `dp_register` instance.

Test Plan:
- Reset: `clear`=1, `MDRin`=0, `read`=0, Mdatain=0x12345678, BusMuxOut=0, run 2 clocks -> `memOut`=0x00000000 throughout.
- Memory load: drop `clear`, then `MDRin`=1, `read`=1, Mdatain=0x87654321, BusMuxOut=0x00000001 -> `memOut`=0x87654321 after the next rising edge, not before.
- Bus load: `MDRin`=1, `read`=0, BusMuxOut=0x00000001, Mdatain=0x87654321 -> `memOut`=0x00000001 after the next rising edge.
- Hold: after loading 0xDEADBEEF, `MDRin`=0, change Mdatain/BusMuxOut to 0xFFFFFFFF for 3 clocks -> `memOut` stays 0xDEADBEEF.
- Async clear: with `memOut`=0xDEADBEEF, raise `clear` mid-cycle (away from an edge) -> `memOut`=0 immediately. Keep `MDRin`=1, `read`=1 through the next edge -> remains 0.
- Clear priority and recovery: `clear`=1 and `MDRin`=1 with Mdatain=0xA5A5A5A5 at an edge -> 0. Release `clear` -> 0xA5A5A5A5 after the following edge.
